tmds_period_sequencer: RTL and testbench

Pixel-clock-domain controller that sits between the TMDS encoders/timing generator and the TMDS serializers. It picks, per pixel cycle, what all three channels carry: control period tokens (sync/CTL), HDMI video preamble, video leading guard band, or encoded video tokens. It delays the input stream by a fixed lookahead so that the preamble and guard band are emitted before each DE rising edge. Its outputs drive the serializer chanN_token inputs directly.

---
 rtl/tmds_period_sequencer_if.sv | 24 ++
 rtl/tmds_period_sequencer.sv | 97 +++++++++
 tb/tb_tmds_period_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/tmds_period_sequencer_if.sv
// Pixel-domain bundle between timing/encoder front end, period sequencer and serializers.
// master = stream source side, slave = the sequencer.
interface tmds_period_sequencer_if;
  logic       de_in;
  logic       hsync_in;
  logic       vsync_in;
  logic [9:0] chan0_video;
  logic [9:0] chan1_video;
  logic [9:0] chan2_video;
  logic [9:0] chan0_token;
  logic [9:0] chan1_token;
  logic [9:0] chan2_token;
  logic       de_out;
  logic       gap_err;

  modport master (
    output de_in, hsync_in, vsync_in, chan0_video, chan1_video, chan2_video,
    input  chan0_token, chan1_token, chan2_token, de_out, gap_err
  );
  modport slave (
    input  de_in, hsync_in, vsync_in, chan0_video, chan1_video, chan2_video,
    output chan0_token, chan1_token, chan2_token, de_out, gap_err
  );
endinterface

// File: rtl/tmds_period_sequencer.sv
// Chooses control / preamble / guard band / video tokens for all three TMDS channels,
// using an L-deep lookahead delay line so preamble and guard precede each DE rise.
module tmds_period_sequencer #(
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2,
  parameter int HDMI_MODE    = 1
) (
  input logic clk,
  input logic rst_n,
  tmds_period_sequencer_if.slave bus
);
  localparam int L  = PREAMBLE_LEN + GUARD_LEN;
  localparam int CW = $clog2(L + 1);
  localparam logic [9:0] CTRL00 = 10'b1101010100;
  localparam logic [9:0] GB_02  = 10'b1011001100;
  localparam logic [9:0] GB_1   = 10'b0100110011;
  localparam logic       HDMI   = (HDMI_MODE != 0);

  typedef struct packed {
    logic            de;
    logic            vs;
    logic            hs;
    logic [2:0][9:0] vid;
  } stage_t;

  typedef enum logic [1:0] {CL_CTRL, CL_PRE, CL_GUARD, CL_VIDEO} cls_e;

  function automatic logic [9:0] ctrl_tok(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  stage_t            in_s, cur;
  stage_t [L-1:0]    dly;
  logic   [L-1:0]    la;
  cls_e              cls;
  logic   [2:0][9:0] tok, tok_nxt;
  logic              de_q, gap_q;
  logic   [CW-1:0]   gap_cnt;

  assign in_s = '{de: bus.de_in, vs: bus.vsync_in, hs: bus.hsync_in,
                  vid: {bus.chan2_video, bus.chan1_video, bus.chan0_video}};
  assign cur  = dly[L-1];

  // la[k-1] = de of the input k cycles after the one leaving the delay line
  always_comb begin
    la = '0;
    for (int k = 1; k < L; k++) la[k-1] = dly[L-1-k].de;
    la[L-1] = bus.de_in;
  end

  // Nearest rise wins, so guard has priority and preamble is cut from its front
  always_comb begin
    cls = CL_CTRL;
    if (cur.de)                          cls = CL_VIDEO;
    else if (HDMI && |la[GUARD_LEN-1:0]) cls = CL_GUARD;
    else if (HDMI && |la[L-1:GUARD_LEN]) cls = CL_PRE;
  end

  always_comb begin
    tok_nxt = {3{CTRL00}};
    case (cls)
      CL_VIDEO: tok_nxt = cur.vid;
      CL_GUARD: tok_nxt = {GB_02, GB_1, GB_02};
      CL_PRE:   tok_nxt = {ctrl_tok(2'b00), ctrl_tok(2'b01), ctrl_tok({cur.vs, cur.hs})};
      default:  tok_nxt[0] = ctrl_tok({cur.vs, cur.hs});
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly     <= '0;
      tok     <= {3{CTRL00}};
      de_q    <= 1'b0;
      gap_q   <= 1'b0;
      gap_cnt <= CW'(L);
    end else begin
      dly   <= {dly[L-2:0], in_s};
      tok   <= tok_nxt;
      de_q  <= cur.de;
      // Input-timed: flags a rise whose preceding blanking could not hold preamble+guard
      gap_q <= HDMI && bus.de_in && (gap_cnt != '0) && (gap_cnt < CW'(L));
      if (bus.de_in)             gap_cnt <= '0;
      else if (gap_cnt < CW'(L)) gap_cnt <= gap_cnt + 1'b1;
    end
  end

  assign bus.chan0_token = tok[0];
  assign bus.chan1_token = tok[1];
  assign bus.chan2_token = tok[2];
  assign bus.de_out      = de_q;
  assign bus.gap_err     = gap_q;
endmodule

// File: tb/tb_tmds_period_sequencer.sv
// Directed bench: HDMI and DVI instances share one stimulus stream; each input cycle
// carries a hand-assigned period label checked 11 cycles later.
module tb_tmds_period_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  tmds_period_sequencer_if ifh ();
  tmds_period_sequencer_if ifd ();

  tmds_period_sequencer u_hdmi (.clk(clk), .rst_n(rst_n), .bus(ifh));
  tmds_period_sequencer #(.HDMI_MODE(0)) u_dvi (.clk(clk), .rst_n(rst_n), .bus(ifd));

  typedef enum {C_CTRL, C_PRE, C_GUARD, C_VIDEO} cls_t;
  typedef struct {
    cls_t       c;
    logic       hs, vs;
    logic [9:0] v0, v1, v2;
  } ent_t;

  ent_t q[$];
  int checks = 0;
  int errors = 0;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;
  localparam logic [9:0] G02 = 10'b1011001100;
  localparam logic [9:0] G1  = 10'b0100110011;

  function automatic logic [9:0] ctl(input logic vs, input logic hs);
    case ({vs, hs})
      2'b00:   return T00;
      2'b01:   return T01;
      2'b10:   return T10;
      default: return T11;
    endcase
  endfunction

  function automatic logic [9:0] exp_tok(input cls_t c, input ent_t e, input int ch);
    case (c)
      C_VIDEO: return (ch == 0) ? e.v0 : (ch == 1) ? e.v1 : e.v2;
      C_GUARD: return (ch == 1) ? G1 : G02;
      C_PRE:   return (ch == 0) ? ctl(e.vs, e.hs) : (ch == 1) ? T01 : T00;
      default: return (ch == 0) ? ctl(e.vs, e.hs) : T00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed %b required %b", tag, obs, req);
    end
  endtask

  task automatic check_out(input ent_t e);
    cls_t cd;
    cd = (e.c == C_VIDEO) ? C_VIDEO : C_CTRL;
    chk("hdmi_ch0", ifh.chan0_token, exp_tok(e.c, e, 0));
    chk("hdmi_ch1", ifh.chan1_token, exp_tok(e.c, e, 1));
    chk("hdmi_ch2", ifh.chan2_token, exp_tok(e.c, e, 2));
    chk("hdmi_de_out", {9'b0, ifh.de_out}, {9'b0, e.c == C_VIDEO});
    chk("dvi_ch0", ifd.chan0_token, exp_tok(cd, e, 0));
    chk("dvi_ch1", ifd.chan1_token, exp_tok(cd, e, 1));
    chk("dvi_ch2", ifd.chan2_token, exp_tok(cd, e, 2));
    chk("dvi_de_out", {9'b0, ifd.de_out}, {9'b0, cd == C_VIDEO});
  endtask

  task automatic zero_fill();
    ent_t z;
    z = '{c: C_CTRL, hs: 1'b0, vs: 1'b0, v0: '0, v1: '0, v2: '0};
    q.delete();
    repeat (11) q.push_back(z);
  endtask

  task automatic reset_state(input string tag);
    chk({tag, "_h0"}, ifh.chan0_token, T00);
    chk({tag, "_h1"}, ifh.chan1_token, T00);
    chk({tag, "_h2"}, ifh.chan2_token, T00);
    chk({tag, "_hde"}, {9'b0, ifh.de_out}, 10'd0);
    chk({tag, "_hgap"}, {9'b0, ifh.gap_err}, 10'd0);
    chk({tag, "_d0"}, ifd.chan0_token, T00);
    chk({tag, "_dde"}, {9'b0, ifd.de_out}, 10'd0);
  endtask

  // One pixel cycle: check outputs for the input 11 cycles back, then drive a new input
  task automatic step(input logic de, input logic hs, input logic vs, input cls_t c,
                      input logic [9:0] vb, input logic ge);
    ent_t e;
    @(negedge clk);
    chk("hdmi_gap_err", {9'b0, ifh.gap_err}, {9'b0, ge});
    chk("dvi_gap_err", {9'b0, ifd.gap_err}, 10'd0);
    if (q.size() == 11) check_out(q.pop_front());
    e = '{c: c, hs: hs, vs: vs, v0: vb, v1: vb ^ 10'h155, v2: ~vb};
    q.push_back(e);
    ifh.de_in = de;  ifh.hsync_in = hs;  ifh.vsync_in = vs;
    ifh.chan0_video = e.v0;  ifh.chan1_video = e.v1;  ifh.chan2_video = e.v2;
    ifd.de_in = de;  ifd.hsync_in = hs;  ifd.vsync_in = vs;
    ifd.chan0_video = e.v0;  ifd.chan1_video = e.v1;  ifd.chan2_video = e.v2;
  endtask

  task automatic blank(input int n, input cls_t c, input logic hs, input logic vs);
    for (int i = 0; i < n; i++) step(1'b0, hs, vs, c, 10'h2a5 + 10'(i), 1'b0);
  endtask

  task automatic video(input int n, input logic [9:0] base, input logic ge);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, C_VIDEO, base + 10'(i), (i == 1) ? ge : 1'b0);
  endtask

  initial begin
    ifh.de_in = 0; ifh.hsync_in = 0; ifh.vsync_in = 0;
    ifh.chan0_video = '0; ifh.chan1_video = '0; ifh.chan2_video = '0;
    ifd.de_in = 0; ifd.hsync_in = 0; ifd.vsync_in = 0;
    ifd.chan0_video = '0; ifd.chan1_video = '0; ifd.chan2_video = '0;

    // Test 1: reset state, then idle blanking
    #1 rst_n = 1'b0;
    #1 reset_state("reset");
    zero_fill();
    repeat (3) step(1'b0, 1'b0, 1'b0, C_CTRL, 10'h000, 1'b0);
    #1 rst_n = 1'b1;
    blank(20, C_CTRL, 1'b0, 1'b0);

    // Test 2 (and 5 on the DVI instance): long blanking with hsync window, then a line
    blank(10, C_CTRL, 1'b0, 1'b0);
    blank(10, C_CTRL, 1'b1, 1'b0);
    blank(10, C_CTRL, 1'b0, 1'b0);
    blank(8, C_PRE, 1'b0, 1'b0);
    blank(2, C_GUARD, 1'b0, 1'b0);
    video(16, 10'h100, 1'b0);

    // Test 3: 5-cycle gap -> 3 preamble (hsync high) + 2 guard, gap_err pulse
    blank(3, C_PRE, 1'b1, 1'b0);
    blank(2, C_GUARD, 1'b0, 1'b0);
    video(8, 10'h200, 1'b1);

    // Test 4: 1-cycle gap -> single guard cycle
    blank(1, C_GUARD, 1'b0, 1'b0);
    video(8, 10'h300, 1'b1);

    // Test 6: line interrupted by reset in its 8th video cycle
    blank(10, C_CTRL, 1'b0, 1'b0);
    blank(8, C_PRE, 1'b0, 1'b1);
    blank(2, C_GUARD, 1'b0, 1'b0);
    video(7, 10'h080, 1'b0);
    step(1'b1, 1'b0, 1'b0, C_VIDEO, 10'h087, 1'b0);
    #2 rst_n = 1'b0;
    #1 reset_state("midline_reset");
    zero_fill();
    repeat (3) step(1'b0, 1'b0, 1'b0, C_CTRL, 10'h000, 1'b0);
    #1 rst_n = 1'b1;
    blank(2, C_CTRL, 1'b0, 1'b0);
    blank(8, C_PRE, 1'b0, 1'b0);
    blank(2, C_GUARD, 1'b0, 1'b0);
    video(8, 10'h3c0, 1'b0);
    blank(15, C_CTRL, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
